// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_rr selector family.
// Packet lock is enabled by defining STREAM_MUX_PKT_LOCK_EN.
package stream_mux_pkg;

   typedef enum logic [0:0] {
      MUX_RR  = 1'b0,
      MUX_SEL = 1'b1
   } mux_mode_e;

   function automatic int chan_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Rotate-priority arbiter: first request at or above ptr wins, wrapping.
// Purely combinational; grant is one-hot with a matching encoded index.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int N    = 8,
   parameter int CH_W = chan_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [CH_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [CH_W-1:0] idx
);

   always_comb begin
      int  j;
      bit  found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = CH_W'(j);
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream selector with a single registered output stage.
// Define STREAM_MUX_PKT_LOCK_EN to keep packets (in_last framing) unbroken.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int N     = 8,
   parameter int WIDTH = 8,
   parameter int MODE  = 0,
   parameter int CH_W  = chan_w(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CH_W-1:0]    s,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [CH_W-1:0]    out_chan,
   output logic               out_last
);

   localparam mux_mode_e MODE_E = (MODE == 1) ? MUX_SEL : MUX_RR;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CH_W-1:0]  out_chan_q, out_chan_d;
   logic             out_last_q, out_last_d;
   logic [CH_W-1:0]  ptr_q, ptr_d;

   logic [N-1:0]     arb_gnt;
   logic [N-1:0]     sel_gnt;
   logic [N-1:0]     gnt;
   logic [CH_W-1:0]  arb_idx;
   logic [CH_W-1:0]  g_idx;
   logic             adv;
   logic             xfer;
   logic [WIDTH-1:0] mux_data;
   logic             mux_last;

`ifdef STREAM_MUX_PKT_LOCK_EN
   logic             lock_q, lock_d;
   logic [CH_W-1:0]  lock_ch_q, lock_ch_d;
`endif

   // Reset also gates acceptance so no beat is taken while held in reset.
   assign adv = (!out_valid_q || out_ready) && !reset;

   generate
      if (MODE_E == MUX_RR) begin : g_rr
         rr_arbiter #(
            .N    (N),
            .CH_W (CH_W)
         ) u_arb (
            .req (in_valid),
            .ptr (ptr_q),
            .gnt (arb_gnt),
            .idx (arb_idx)
         );
      end else begin : g_sel
         assign arb_gnt = '0;
         assign arb_idx = '0;
      end
   endgenerate

   always_comb begin
      sel_gnt = '0;
      for (int i = 0; i < N; i++) begin
         sel_gnt[i] = in_valid[i] && (s == CH_W'(i));
      end
   end

   always_comb begin
      if (MODE_E == MUX_SEL) begin
         gnt   = sel_gnt;
         g_idx = s;
      end else begin
         gnt   = arb_gnt;
         g_idx = arb_idx;
      end
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (lock_q) begin
         for (int i = 0; i < N; i++) begin
            gnt[i] = in_valid[i] && (lock_ch_q == CH_W'(i));
         end
         g_idx = lock_ch_q;
      end
`endif
   end

   assign in_ready = gnt & {N{adv}};
   assign xfer     = adv && (|gnt);

   always_comb begin
      mux_data = '0;
      mux_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            mux_data = in_data[i*WIDTH +: WIDTH];
            mux_last = in_last[i];
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_last_d  = out_last_q;
      ptr_d       = ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_d      = lock_q;
      lock_ch_d   = lock_ch_q;
`endif
      if (adv) begin
         out_valid_d = xfer;
      end
      if (xfer) begin
         out_data_d = mux_data;
         out_chan_d = g_idx;
         out_last_d = mux_last;
         if (MODE_E == MUX_RR) begin
            ptr_d = (g_idx == CH_W'(N - 1)) ? '0 : g_idx + CH_W'(1);
         end
`ifdef STREAM_MUX_PKT_LOCK_EN
         lock_d    = !mux_last;
         lock_ch_d = g_idx;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_last_q  <= 1'b0;
         ptr_q       <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
         lock_q      <= 1'b0;
         lock_ch_q   <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_last_q  <= out_last_d;
         ptr_q       <= ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed literal checks plus random traffic
// compared every cycle against a queue-free behavioural model.
module tb_stream_mux_rr;

   typedef struct {
      bit ov;
      int data;
      int chan;
      bit last;
      int ptr;
      bit lk;
      int lch;
   } ms_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic [1:0]  a_s;
   logic [3:0]  a_valid, a_ready, a_last;
   logic [31:0] a_data;
   logic        a_ordy, a_out_valid, a_out_last;
   logic [7:0]  a_out_data;
   logic [1:0]  a_out_chan;

   logic [2:0]  b_s;
   logic [5:0]  b_valid, b_ready, b_last;
   logic [47:0] b_data;
   logic        b_ordy, b_out_valid, b_out_last;
   logic [7:0]  b_out_data;
   logic [2:0]  b_out_chan;

   int n_chk = 0;
   int n_fail = 0;

   ms_t ma, mb, na, nb;
   logic [7:0] ra, rb;

   always #5 clk = ~clk;

   stream_mux_rr #(.N(4), .WIDTH(8), .MODE(0)) u_a (
      .clk       (clk),
      .reset     (reset),
      .s         (a_s),
      .in_valid  (a_valid),
      .in_ready  (a_ready),
      .in_data   (a_data),
      .in_last   (a_last),
      .out_valid (a_out_valid),
      .out_ready (a_ordy),
      .out_data  (a_out_data),
      .out_chan  (a_out_chan),
      .out_last  (a_out_last)
   );

   stream_mux_rr #(.N(6), .WIDTH(8), .MODE(1)) u_b (
      .clk       (clk),
      .reset     (reset),
      .s         (b_s),
      .in_valid  (b_valid),
      .in_ready  (b_ready),
      .in_data   (b_data),
      .in_last   (b_last),
      .out_valid (b_out_valid),
      .out_ready (b_ordy),
      .out_data  (b_out_data),
      .out_chan  (b_out_chan),
      .out_last  (b_out_last)
   );

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  nm, $time, act, exp);
      end
   endtask

   // Model: pick the channel from the stated rules, then apply one edge.
   function automatic void model(
      input  int          n,
      input  bit          sel,
      input  ms_t         cur,
      input  logic [7:0]  v,
      input  int          s,
      input  logic [63:0] d,
      input  logic [7:0]  l,
      input  bit          ordy,
      output logic [7:0]  rdy,
      output ms_t         nxt
   );
      int g;
      bit adv;
      nxt = cur;
      rdy = '0;
      g   = -1;
      adv = !cur.ov || ordy;
      if (cur.lk) begin
         if (v[cur.lch]) g = cur.lch;
      end else if (sel) begin
         if (s < n && v[s]) g = s;
      end else begin
         for (int k = 0; k < n; k++)
            if (g < 0 && v[(cur.ptr + k) % n]) g = (cur.ptr + k) % n;
      end
      if (!adv) return;
      if (g < 0) begin
         nxt.ov = 1'b0;
         return;
      end
      rdy[g]   = 1'b1;
      nxt.ov   = 1'b1;
      nxt.data = int'(d[g*8 +: 8]);
      nxt.chan = g;
      nxt.last = l[g];
      if (!sel) nxt.ptr = (g + 1) % n;
`ifdef STREAM_MUX_PKT_LOCK_EN
      nxt.lk  = !l[g];
      nxt.lch = g;
`endif
   endfunction

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
   end

   always @(negedge clk) begin
      model(4, 1'b0, ma, {4'b0, a_valid}, 0, {32'b0, a_data},
            {4'b0, a_last}, a_ordy, ra, na);
      model(6, 1'b1, mb, {2'b0, b_valid}, int'(b_s), {16'b0, b_data},
            {2'b0, b_last}, b_ordy, rb, nb);
      if (reset) begin
         ma = '{default: 0};
         mb = '{default: 0};
         na = '{default: 0};
         nb = '{default: 0};
         ra = '0;
         rb = '0;
      end
      cmp("m_a_ready", a_ready, ra[3:0]);
      cmp("m_a_valid", a_out_valid, ma.ov);
      if (ma.ov || reset) begin
         cmp("m_a_data", a_out_data, ma.data);
         cmp("m_a_chan", a_out_chan, ma.chan);
         cmp("m_a_last", a_out_last, ma.last);
      end
      cmp("m_b_ready", b_ready, rb[5:0]);
      cmp("m_b_valid", b_out_valid, mb.ov);
      if (mb.ov || reset) begin
         cmp("m_b_data", b_out_data, mb.data);
         cmp("m_b_chan", b_out_chan, mb.chan);
         cmp("m_b_last", b_out_last, mb.last);
      end
      ma = na;
      mb = nb;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int seq [4];
   int exp_seq [4];
   int bk, got;
   bit r0;

   initial begin
      a_s = '0; a_valid = '0; a_last = 4'hF; a_ordy = 1'b0;
      a_data = 32'h13121110;
      b_s = '0; b_valid = '0; b_last = 6'h3F; b_ordy = 1'b1;
      b_data = '0;
      #1;
      reset = 1'b1;
      a_valid = 4'hF;
      b_valid = 6'h3F;
      @(negedge clk);
      cmp("rst_a_valid", a_out_valid, 0);
      cmp("rst_a_chan", a_out_chan, 0);
      cmp("rst_a_ready", a_ready, 0);
      cmp("rst_b_ready", b_ready, 0);

      tick();
      reset = 1'b0;
      a_ordy = 1'b1;
      b_valid = '0;
      @(negedge clk);
      cmp("first_ready", a_ready, 4'b0001);
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         cmp("fair_valid", a_out_valid, 1);
         cmp("fair_chan", a_out_chan, i % 4);
      end
      tick();
      a_valid = '0;
      tick();
      @(negedge clk);
      cmp("drain_valid", a_out_valid, 0);

      tick();
      a_valid = 4'b0100;
      a_data = 32'h00A50000;
      a_ordy = 1'b0;
      @(negedge clk);
      cmp("bp_first_ready", a_ready, 4'b0100);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         cmp("bp_valid", a_out_valid, 1);
         cmp("bp_data", a_out_data, 8'hA5);
         cmp("bp_chan", a_out_chan, 2);
         cmp("bp_ready", a_ready, 4'b0000);
      end
      tick();
      a_ordy = 1'b1;
      a_data = 32'h005A0000;
      @(negedge clk);
      cmp("bp_release_ready", a_ready, 4'b0100);
      tick();
      a_valid = 4'b0010;
      @(negedge clk);
      cmp("bp_next_data", a_out_data, 8'h5A);
      cmp("wrap_ready1", a_ready, 4'b0010);
      tick();
      a_valid = 4'b0001;
      @(negedge clk);
      cmp("wrap_chan1", a_out_chan, 1);
      cmp("wrap_ready0", a_ready, 4'b0001);
      tick();
      a_valid = 4'b1000;
      @(negedge clk);
      cmp("wrap_chan0", a_out_chan, 0);
      tick();
      a_valid = '0;
      @(negedge clk);
      cmp("wrap_chan3", a_out_chan, 3);
      tick();
      @(negedge clk);

`ifdef STREAM_MUX_PKT_LOCK_EN
      exp_seq = '{0, 0, 0, 1};
`else
      exp_seq = '{0, 1, 0, 1};
`endif
      seq = '{-1, -1, -1, -1};
      bk = 0;
      got = 0;
      r0 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (r0) bk++;
         a_valid = {2'b00, 1'b1, bk < 3};
         a_data  = {16'h0, 8'h11, 8'(8'hB0 + bk)};
         a_last  = {2'b11, 1'b1, bk == 2};
         @(negedge clk);
         r0 = a_ready[0];
         if (a_out_valid && got < 4) begin
            seq[got] = int'(a_out_chan);
            got++;
         end
      end
      cmp("lock_beats", got, 4);
      for (int i = 0; i < 4; i++) cmp("lock_seq", seq[i], exp_seq[i]);
      tick();
      a_valid = '0;
      a_last = 4'hF;
      tick();

      tick();
      b_s = 3'd5;
      b_valid = 6'b100000;
      b_data = {8'h3C, 40'h0};
      @(negedge clk);
      cmp("sel_ready", b_ready, 6'b100000);
      tick();
      b_s = 3'd7;
      b_valid = 6'h3F;
      @(negedge clk);
      cmp("sel_data", b_out_data, 8'h3C);
      cmp("sel_chan", b_out_chan, 5);
      cmp("sel_bad_ready", b_ready, 0);
      tick();
      @(negedge clk);
      cmp("sel_drop", b_out_valid, 0);

      for (int c = 0; c < 3000; c++) begin
         tick();
         reset   = ($urandom_range(0, 199) == 0);
         a_valid = 4'($urandom);
         a_data  = $urandom;
         a_last  = 4'($urandom | $urandom);
         a_ordy  = ($urandom_range(0, 3) != 0);
         b_valid = 6'($urandom);
         b_data  = {16'($urandom), $urandom};
         b_last  = 6'($urandom | $urandom);
         b_s     = 3'($urandom);
         b_ordy  = ($urandom_range(0, 3) != 0);
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-to-1 streaming selector; successor to the fixed 8-to-1 combinational mux.
- Each input is a valid/ready channel of WIDTH bits. One channel is chosen per beat, by round-robin arbitration or by an explicit select input (MODE).
- The chosen beat goes into a single registered output stage.
- Sits between multiple producers (e.g. per-source datapaths) and one shared consumer.

Parameters:
- N, 8, number of input channels (≥2).
- WIDTH, 8, data bits per channel.
- MODE, 0, 0 = round-robin arbitration, 1 = explicit select via s.
- CH_W, $clog2(N), width of channel index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- s  input  CH_W  explicit channel select; used only when MODE=1.
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready.
- in_data  input  N*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  N  per-channel end-of-packet flag.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered data.
- out_chan  output  CH_W  index of the source channel for out_data.
- out_last  output  1  registered last flag.

Behaviour:
- Reset (asynchronous, active-high) clears out_valid, out_data, out_chan, out_last, rr pointer ptr and lock state to 0.
- Enable: adv = !out_valid || out_ready. Only one output register stage, so full throughput is 1 beat/cycle with back-to-back out_ready=1. Latency from input transfer to out_valid is 1 cycle.
- Grant is one-hot and combinational:
  - MODE=0: grant goes to the first asserted in_valid bit, searching upward from ptr with wrap N-1→0.
  - MODE=1: grant[s] = in_valid[s]. If s ≥ N, no grant.
- in_ready[i] = grant[i] && adv. At most one in_ready bit is high per cycle. in_ready never depends on out_valid of the same channel beyond adv.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On that clock edge:
  - out_data, out_last and out_chan are loaded from channel g.
  - out_valid is set to 1.
  - MODE=0: ptr <= (g+1) mod N, wrapping from N-1 to 0.
- When adv=1 and there is no transfer, out_valid is cleared to 0.
- Stall: while out_valid && !out_ready, the output register holds out_data/out_chan/out_last stable and all in_ready bits are 0.
- No input valid: out_valid drops after the pending beat is consumed; ptr is unchanged.
- A channel deasserting in_valid without a transfer is legal. Grant re-evaluates every cycle; no state is kept for it.
- Reset asserted mid-stream drops any held beat. No partial output is produced after reset releases.

Optional Feature:
- Macro STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - A transfer with in_last=0 sets lock and records the channel as lock_ch.
  - While locked, grant is forced to lock_ch (if it is valid); ptr and s are ignored.
  - A transfer with in_last=1 from lock_ch clears lock. ptr then advances as normal.
  - Packets from different channels are never interleaved.
- Undefined: no lock state exists; arbitration is per beat and in_last passes through as plain data.

Decomposition:
- Package stream_mux_pkg holds:
  - typedef enum mux_mode_e {MUX_RR=0, MUX_SEL=1};
  - function chan_w(n), returning max(1, $clog2(n)).
- Sub-module rr_arbiter (parameter N): in req[N], ptr[CH_W]; out one-hot gnt[N] and encoded idx. It is purely combinational rotate-priority logic, instantiated only when MODE=0.
- The top level owns the output register, ptr and lock.

Test Plan:
- Reset: assert reset with all in_valid=1 → out_valid=0, out_chan=0, in_ready=0 during reset; first beat after release comes from ch0.
- RR fairness (N=4, MODE=0): all four channels valid continuously, out_ready=1 → out_chan sequence is 0,1,2,3,0,1, one beat per cycle after 1-cycle latency.
- Backpressure: ch2 valid with data 0xA5, out_ready=0 for 3 cycles → out_data=0xA5 held stable, in_ready=0000; with out_ready=1 the next ch2 beat follows on the next cycle.
- Wrap and sparse requests: ptr=3, only ch1 valid → grant ch1, then ptr=2. Next cycle only ch0 valid → grant ch0.
- MODE=1 select: s=5 with in_valid[5]=1 and data 0x3C → out_data=0x3C, out_chan=5. With N=6, s=7 → no in_ready and out_valid drops.
- STREAM_MUX_PKT_LOCK_EN: ch0 sends a 3-beat packet while ch1 is valid throughout → out_chan 0,0,0 (last on 3rd beat), then 1. Same stimulus without the macro → 0,1,0,1 interleaved.
